// File: rtl/parking_sensor_conditioner.sv
// ----------------------------------------------------------------------------
// parking_sensor_conditioner
//
// Input conditioning stage in front of parking_fsm. Each raw input bit passes
// through a two-flop synchroniser. The entry and exit beams are then debounced
// by independent channel FSMs, and the 2-bit slot switch by a shared counter.
// The block emits single-cycle entry/exit event pulses. Exit takes priority
// over entry, and a colliding entry is deferred by one cycle. Entries are
// dropped (and reported) while the lot is full.
//
// Ports
//   clk           in   1  system clock, rising edge
//   reset         in   1  asynchronous active-low reset
//   entry_raw     in   1  raw entry beam (1 = vehicle present), asynchronous
//   exit_raw      in   1  raw exit beam (1 = vehicle present), asynchronous
//   switch_raw    in   2  raw slot-select switch, asynchronous
//   full          in   1  lot-full flag from parking_fsm
//   entry_sensor  out  1  one-cycle entry event pulse
//   exit_sensor   out  1  one-cycle exit event pulse
//   switch        out  2  debounced slot select, stable during exit pulses
//   entry_denied  out  1  one-cycle pulse when an entry is dropped due to full
//   busy          out  1  a channel is not idle or an entry is pending
// ----------------------------------------------------------------------------
module parking_sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       entry_raw,
    input  logic       exit_raw,
    input  logic [1:0] switch_raw,
    input  logic       full,
    output logic       entry_sensor,
    output logic       exit_sensor,
    output logic [1:0] switch,
    output logic       entry_denied,
    output logic       busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Channel indices into the per-channel vectors.
    localparam int CH_ENTRY = 0;
    localparam int CH_EXIT  = 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMING    = 2'd1,
        ACTIVE    = 2'd2,
        RELEASING = 2'd3
    } ch_state_e;

    // ------------------------------------------------------------------
    // Two-flop synchronisers: bit 0 entry, bit 1 exit, bits 3:2 switch.
    // ------------------------------------------------------------------
    logic [3:0] raw_bits;
    logic [3:0] sync_s;

    assign raw_bits = {switch_raw, exit_raw, entry_raw};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sync
            logic meta_q;
            logic stab_q;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    meta_q <= 1'b0;
                    stab_q <= 1'b0;
                end else begin
                    meta_q <= raw_bits[gi];
                    stab_q <= meta_q;
                end
            end

            assign sync_s[gi] = stab_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Beam channel FSMs (0 = entry, 1 = exit). An event qualifies only on
    // the ARMING -> ACTIVE transition, so each vehicle produces one event.
    // ------------------------------------------------------------------
    logic [1:0] ch_qual;
    logic [1:0] ch_busy;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            ch_state_e        state_q, state_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             s;
            logic             qual;
            logic             not_idle;

            assign s = sync_s[gi];

            // State register.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                end
            end

            // Next-state logic. The counter only ever reaches CNT_MAX inside
            // ARMING/RELEASING, where that value forces a transition that
            // clears it, so it saturates rather than wraps.
            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                case (state_q)
                    IDLE: begin
                        cnt_d = '0;
                        if (s) begin
                            state_d = ARMING;
                        end
                    end
                    ARMING: begin
                        if (!s) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else if (cnt_q == CNT_MAX) begin
                            state_d = ACTIVE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                    ACTIVE: begin
                        cnt_d = '0;
                        if (!s) begin
                            state_d = RELEASING;
                        end
                    end
                    RELEASING: begin
                        if (s) begin
                            state_d = ACTIVE;
                            cnt_d   = '0;
                        end else if (cnt_q == CNT_MAX) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end

            // Output logic.
            always_comb begin
                qual     = (state_q == ARMING) && s && (cnt_q == CNT_MAX);
                not_idle = (state_q != IDLE);
            end

            assign ch_qual[gi] = qual;
            assign ch_busy[gi] = not_idle;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Arbitration and full gating. The pulses are registered, so a
    // qualification seen in a cycle appears on the output after the next
    // edge. full is sampled in the cycle the entry is actually issued.
    // ------------------------------------------------------------------
    logic entry_sensor_q, entry_sensor_d;
    logic exit_sensor_q,  exit_sensor_d;
    logic entry_denied_q, entry_denied_d;
    logic pending_q,      pending_d;
    logic entry_req;

    always_comb begin
        entry_sensor_d = 1'b0;
        exit_sensor_d  = ch_qual[CH_EXIT];
        entry_denied_d = 1'b0;
        pending_d      = pending_q;
        entry_req      = pending_q | ch_qual[CH_ENTRY];

        if (ch_qual[CH_EXIT]) begin
            // Exit wins the slot. A competing entry is held for one cycle.
            // A new entry cannot qualify while one is pending, because the
            // channel is then ACTIVE, so one entry of storage is enough.
            if (entry_req) begin
                pending_d = 1'b1;
            end
        end else if (entry_req) begin
            pending_d = 1'b0;
            if (full) begin
                entry_denied_d = 1'b1;
            end else begin
                entry_sensor_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            entry_sensor_q <= 1'b0;
            exit_sensor_q  <= 1'b0;
            entry_denied_q <= 1'b0;
            pending_q      <= 1'b0;
        end else begin
            entry_sensor_q <= entry_sensor_d;
            exit_sensor_q  <= exit_sensor_d;
            entry_denied_q <= entry_denied_d;
            pending_q      <= pending_d;
        end
    end

    // ------------------------------------------------------------------
    // Switch debounce. A change of the synchronised value restarts the count.
    // An update is held off on the edge where an exit pulse starts, so
    // parking_fsm sees a stable slot for the whole pulse. The counter stays
    // at CNT_MAX and the update lands on the following edge.
    // ------------------------------------------------------------------
    logic [1:0]       s_sw;
    logic [1:0]       sw_prev_q, sw_prev_d;
    logic [1:0]       switch_q, switch_d;
    logic [CNT_W-1:0] sw_cnt_q, sw_cnt_d;

    assign s_sw = sync_s[3:2];

    always_comb begin
        sw_prev_d = s_sw;
        switch_d  = switch_q;
        sw_cnt_d  = sw_cnt_q;
        if ((s_sw != sw_prev_q) || (s_sw == switch_q)) begin
            sw_cnt_d = '0;
        end else if (sw_cnt_q == CNT_MAX) begin
            if (!exit_sensor_d) begin
                switch_d = s_sw;
                sw_cnt_d = '0;
            end
        end else begin
            sw_cnt_d = sw_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_prev_q <= 2'b00;
            switch_q  <= 2'b00;
            sw_cnt_q  <= '0;
        end else begin
            sw_prev_q <= sw_prev_d;
            switch_q  <= switch_d;
            sw_cnt_q  <= sw_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs.
    // ------------------------------------------------------------------
    assign entry_sensor = entry_sensor_q;
    assign exit_sensor  = exit_sensor_q;
    assign entry_denied = entry_denied_q;
    assign switch       = switch_q;
    assign busy         = (|ch_busy) | pending_q;

endmodule

// File: tb/tb_parking_sensor_conditioner.sv
// ----------------------------------------------------------------------------
// tb_parking_sensor_conditioner
//
// Directed bench for parking_sensor_conditioner with DEBOUNCE_CYCLES = 4.
// Inputs change 1 ns after a rising edge. Outputs are sampled at the same
// point, so "edge e" means the e-th rising edge after the input change.
// ----------------------------------------------------------------------------
module tb_parking_sensor_conditioner;

    logic       clk;
    logic       reset;
    logic       entry_raw;
    logic       exit_raw;
    logic [1:0] switch_raw;
    logic       full;
    logic       entry_sensor;
    logic       exit_sensor;
    logic [1:0] switch;
    logic       entry_denied;
    logic       busy;

    int n_checks;
    int n_pass;

    parking_sensor_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .entry_raw    (entry_raw),
        .exit_raw     (exit_raw),
        .switch_raw   (switch_raw),
        .full         (full),
        .entry_sensor (entry_sensor),
        .exit_sensor  (exit_sensor),
        .switch       (switch),
        .entry_denied (entry_denied),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) begin
            n_pass++;
            $display("check %-24s got %0h expected %0h ok", tag, obs, exp_v);
        end else begin
            $display("FAIL %-24s got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        reset      = 1'b0;
        entry_raw  = 1'b0;
        exit_raw   = 1'b0;
        switch_raw = 2'b00;
        full       = 1'b0;

        // Reset state.
        settle(3);
        check_eq("rst_entry_sensor", 32'(entry_sensor), 32'd0);
        check_eq("rst_exit_sensor",  32'(exit_sensor),  32'd0);
        check_eq("rst_switch",       32'(switch),       32'd0);
        check_eq("rst_entry_denied", 32'(entry_denied), 32'd0);
        check_eq("rst_busy",         32'(busy),         32'd0);
        reset = 1'b1;
        settle(2);

        // Entry held: a single pulse after edge 7, and nothing further.
        entry_raw = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            check_eq($sformatf("entry_e%0d", e), 32'(entry_sensor), 32'(e == 7));
        end
        check_eq("entry_held_busy", 32'(busy), 32'd1);
        entry_raw = 1'b0;
        settle(12);
        check_eq("entry_released_busy", 32'(busy), 32'd0);

        // Three-cycle blip is rejected.
        begin
            int pulses;
            pulses    = 0;
            entry_raw = 1'b1;
            for (int e = 1; e <= 12; e++) begin
                tick();
                if (e == 3) entry_raw = 1'b0;
                if (entry_sensor) pulses++;
            end
            check_eq("blip_pulses", 32'(pulses), 32'd0);
            check_eq("blip_busy",   32'(busy),   32'd0);
        end

        // Entry and exit together: exit at edge 7, entry at edge 8.
        entry_raw = 1'b1;
        exit_raw  = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            check_eq($sformatf("coll_exit_e%0d", e),  32'(exit_sensor),  32'(e == 7));
            check_eq($sformatf("coll_entry_e%0d", e), 32'(entry_sensor), 32'(e == 8));
        end
        entry_raw = 1'b0;
        exit_raw  = 1'b0;
        settle(12);

        // Full: the entry is denied at edge 7 and never issued.
        full      = 1'b1;
        entry_raw = 1'b1;
        begin
            int issued;
            issued = 0;
            for (int e = 1; e <= 10; e++) begin
                tick();
                if (entry_sensor) issued++;
                check_eq($sformatf("full_denied_e%0d", e), 32'(entry_denied), 32'(e == 7));
            end
            check_eq("full_entry_issued", 32'(issued), 32'd0);
        end
        entry_raw = 1'b0;
        settle(12);
        full = 1'b0;

        // Switch to 2'b10: switch is still 0 at edge 6 and 2'b10 from edge 7.
        switch_raw = 2'b10;
        for (int e = 1; e <= 9; e++) begin
            tick();
            if (e >= 6) check_eq($sformatf("sw10_e%0d", e), 32'(switch), (e >= 7) ? 32'd2 : 32'd0);
        end

        // Two-cycle glitch to 2'b01 leaves switch at 2'b10.
        begin
            int changes;
            changes    = 0;
            switch_raw = 2'b01;
            for (int e = 1; e <= 12; e++) begin
                tick();
                if (e == 2) switch_raw = 2'b10;
                if (switch != 2'b10) changes++;
            end
            check_eq("sw_glitch_changes", 32'(changes), 32'd0);
            check_eq("sw_glitch_value",   32'(switch),  32'd2);
        end

        // Stable move to 2'b01.
        switch_raw = 2'b01;
        settle(10);
        check_eq("sw01_value", 32'(switch), 32'd1);

        // The switch update collides with an exit pulse. It is held during the
        // pulse at edge 7 and lands at edge 8.
        switch_raw = 2'b10;
        exit_raw   = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            tick();
            check_eq($sformatf("swx_exit_e%0d", e), 32'(exit_sensor), 32'(e == 7));
            if (e >= 6) check_eq($sformatf("swx_switch_e%0d", e), 32'(switch), (e >= 8) ? 32'd2 : 32'd1);
        end
        exit_raw = 1'b0;
        settle(12);

        // Reset mid-ARMING: outputs clear at once. After release, a full
        // debounce is needed again.
        entry_raw = 1'b1;
        settle(4);
        check_eq("arming_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check_eq("async_rst_busy",   32'(busy),         32'd0);
        check_eq("async_rst_switch", 32'(switch),       32'd0);
        check_eq("async_rst_entry",  32'(entry_sensor), 32'd0);
        settle(2);
        reset = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            check_eq($sformatf("post_rst_entry_e%0d", e), 32'(entry_sensor), 32'(e == 7));
        end
        entry_raw = 1'b0;
        settle(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
